layer_output_serializer: RTL
============================

// Module: layer_output_serializer
// PURPOSE
//  Downstream of a layer's neuron array. Collects one result word from each of
//  numNeurons parallel neuron outputs, then streams the words one per cycle as a
//  data/valid stream. That stream drives the myinput/myinputValid broadcast of
//  the next layer. Lane 0 is sent first. Adds no arithmetic; buffering and
//  sequencing only.
// PARAMETERS
//  numNeurons  10  neurons in producing layer = words per output frame
//  dataWidth   16  width of each neuron output / stream word
// PORTS
//  clk             in   1                      single clock, rising edge
//  rst             in   1                      asynchronous, active-low reset
//  neuron_out      in   numNeurons*dataWidth   lane k = bits [k*dataWidth +: dataWidth]
//  neuron_valid    in   numNeurons             lane k result valid (1-cycle pulse)
//  clear_overflow  in   1                      sync clear of overflow flag
//  data_out        out  dataWidth              serialized word
//  data_valid      out  1                      data_out valid this cycle
//  frame_done      out  1                      pulse concurrent with last word
//  busy            out  1                      high in COLLECT (>=1 lane held) or SHIFT
//  overflow        out  1                      sticky: result arrived while SHIFT
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, all capture flags=0, buffer=0.
//   Outputs: data_out=0, data_valid=0, frame_done=0, busy=0, overflow=0.
//   Reset mid-frame discards the frame; no partial output after release.
//  Storage: numNeurons x dataWidth register buffer, plus a 1-bit captured flag
//   per lane. Shift counter is $clog2(numNeurons)+1 bits wide.
//  IDLE/COLLECT capture rule:
//   - On any cycle with neuron_valid[k]=1, buffer[k] <= lane k and flag[k] <= 1.
//   - Lanes may arrive in the same cycle or in different cycles.
//   - A repeat valid on an already-flagged lane overwrites it; newest value wins.
//  Transitions:
//   - IDLE -> COLLECT on the first valid that does not complete the frame.
//   - IDLE or COLLECT -> SHIFT on the cycle the last missing flag is set,
//     including the case where all lanes arrive in one cycle.
//  SHIFT:
//   - Last capture at edge T: word k appears at edge T+1+k with data_valid=1.
//     k = 0..numNeurons-1; no gaps; no backpressure.
//   - frame_done=1 only with word numNeurons-1.
//   - Next edge: flags cleared, state -> IDLE, data_valid=0.
//   - data_out holds its last value when data_valid=0.
//  Simultaneous/boundary cases:
//   - neuron_valid during SHIFT: data ignored, overflow <= 1, stream unaffected.
//   - neuron_valid in the cycle of the IDLE return (after the last word) is
//     accepted normally and starts a new frame.
//   - clear_overflow and a new overflow event in the same cycle: overflow stays 1.
//   - numNeurons=1: a single valid gives one word next cycle, frame_done=1.
//  Throughput: >= numNeurons+1 cycles per frame.
// TESTING
//  1. Reset, then all 10 lanes valid in one cycle, lane k=k+1. Expect data_out
//     1..10 on 10 consecutive cycles starting next cycle; frame_done with 10;
//     busy low after.
//  2. Lanes valid one per cycle in order 9..0 (value 16'h0100+k). Expect no
//     output until lane 0 arrives, then 0x0100..0x0109 in order.
//  3. Lane 3 valid twice (0xAAAA, then 0x5555) before the frame completes.
//     Expect word 3 = 0x5555.
//  4. All lanes valid again during SHIFT of frame 1. Expect frame 1 stream
//     intact and overflow=1. Then clear_overflow -> overflow=0.
//  5. rst pulsed low while word 4 is out. Expect all outputs 0 immediately,
//     no further words, and a clean new frame after release.
//  6. Two full frames back-to-back, with frame 2 valid on the IDLE-return
//     cycle. Expect 20 words with exactly one idle cycle between frames and
//     two frame_done pulses.

Source files
------------

// File: rtl/layer_output_serializer.sv
// Collects one word per neuron lane, then streams the frame lane 0 first, one word per
// cycle. Results arriving while the frame is being streamed are dropped and flagged.
module layer_output_serializer #(
    parameter int unsigned NumNeurons = 10,
    parameter int unsigned DataWidth  = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumNeurons*DataWidth-1:0] neuron_out_i,
    input  logic [NumNeurons-1:0]           neuron_valid_i,
    input  logic                            clear_overflow_i,
    output logic [DataWidth-1:0]            data_out_o,
    output logic                            data_valid_o,
    output logic                            frame_done_o,
    output logic                            busy_o,
    output logic                            overflow_o
);

    localparam int unsigned CntW = $clog2(NumNeurons) + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StShift} state_e;

    state_e                               state_q, state_d;
    logic [NumNeurons-1:0]                flag_q, flag_d;
    logic [NumNeurons-1:0][DataWidth-1:0] buf_q, buf_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [DataWidth-1:0]                 data_q, data_d;
    logic                                 valid_q, valid_d;
    logic                                 done_q, done_d;
    logic                                 ovf_q, ovf_d;
    logic [NumNeurons-1:0]                flag_base;
    logic                                 accept;

    always_comb begin
        state_d   = state_q;
        flag_d    = flag_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        ovf_d     = ovf_q & ~clear_overflow_i;
        flag_base = flag_q;
        accept    = 1'b1;

        if (state_q == StShift) begin
            if (cnt_q < CntW'(NumNeurons)) begin
                for (int k = 0; k < int'(NumNeurons); k++) begin
                    if (cnt_q == CntW'(k)) begin
                        data_d = buf_q[k];
                    end
                end
                valid_d = 1'b1;
                done_d  = (cnt_q == CntW'(NumNeurons - 1));
                cnt_d   = cnt_q + 1'b1;
                accept  = 1'b0;
                // A set event wins over a same-cycle clear.
                if (|neuron_valid_i) begin
                    ovf_d = 1'b1;
                end
            end else begin
                // Return cycle: the old frame is retired and a new one may start here.
                flag_base = '0;
                state_d   = StIdle;
            end
        end

        if (accept) begin
            for (int k = 0; k < int'(NumNeurons); k++) begin
                if (neuron_valid_i[k]) begin
                    buf_d[k] = neuron_out_i[k*DataWidth +: DataWidth];
                end
            end
            flag_d = flag_base | neuron_valid_i;
            if (&flag_d) begin
                state_d = StShift;
                cnt_d   = '0;
            end else if (|flag_d) begin
                state_d = StCollect;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            flag_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = valid_q;
    assign frame_done_o = done_q;
    assign busy_o       = (state_q != StIdle);
    assign overflow_o   = ovf_q;

endmodule
